// File: rtl/mem_wb_stage_if.sv
// Memory/write-back stage bus: memory-stage inputs, pipeline control and the
// register-file write port. Optional MEMWB_FWD_EN adds the forwarding outputs.
interface mem_wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             inValid;
  logic             inRegWrite;
  logic             inMemToReg;
  logic [2:0]       inLoadType;
  logic [4:0]       inWriteRes;
  logic [31:0]      inAluResult;
  logic [31:0]      inMemData;
  logic             stall;
  logic             flush;
  logic             regWrite;
  logic [4:0]       writeRes;
  logic [31:0]      writeData;
  logic             outValid;
  logic [CNT_W-1:0] retireCnt;
  logic             alignErr;
`ifdef MEMWB_FWD_EN
  logic             fwdValid;
  logic [4:0]       fwdRes;
  logic [31:0]      fwdData;

  modport master (
    output inValid, inRegWrite, inMemToReg, inLoadType, inWriteRes,
           inAluResult, inMemData, stall, flush,
    input  regWrite, writeRes, writeData, outValid, retireCnt, alignErr,
           fwdValid, fwdRes, fwdData
  );
  modport slave (
    input  inValid, inRegWrite, inMemToReg, inLoadType, inWriteRes,
           inAluResult, inMemData, stall, flush,
    output regWrite, writeRes, writeData, outValid, retireCnt, alignErr,
           fwdValid, fwdRes, fwdData
  );
`else
  modport master (
    output inValid, inRegWrite, inMemToReg, inLoadType, inWriteRes,
           inAluResult, inMemData, stall, flush,
    input  regWrite, writeRes, writeData, outValid, retireCnt, alignErr
  );
  modport slave (
    input  inValid, inRegWrite, inMemToReg, inLoadType, inWriteRes,
           inAluResult, inMemData, stall, flush,
    output regWrite, writeRes, writeData, outValid, retireCnt, alignErr
  );
`endif
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: captures the memory-stage result, extracts load data
// (big-endian byte/halfword with sign/zero extension), suppresses writes to x0
// and misaligned loads, counts retired writes and flags alignment errors.
// Optional feature macro MEMWB_FWD_EN: mirrors the write port on fwd* outputs.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input logic            clk,
  input logic            reset,
  mem_wb_stage_if.slave  bus
);

  logic              valid_q, valid_d;
  logic              rw_q, rw_d;
  logic              m2r_q, m2r_d;
  logic [2:0]        ltype_q, ltype_d;
  logic [4:0]        res_q, res_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              aerr_q, aerr_d;

  logic [1:0]        addr_lo;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;
  logic              mis_raw;
  logic              misaligned;
  logic              reg_write;

  // Next-state of the holding register: flush kills the slot, stall holds it.
  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    ltype_d = ltype_q;
    res_d   = res_q;
    alu_d   = alu_q;
    mdata_d = mdata_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d = bus.inValid;
      rw_d    = bus.inRegWrite;
      m2r_d   = bus.inMemToReg;
      ltype_d = bus.inLoadType;
      res_d   = bus.inWriteRes;
      alu_d   = bus.inAluResult;
      mdata_d = bus.inMemData;
    end
  end

  // Holding register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      ltype_q <= 3'd0;
      res_q   <= 5'd0;
      alu_q   <= '0;
      mdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      ltype_q <= ltype_d;
      res_q   <= res_d;
      alu_q   <= alu_d;
      mdata_q <= mdata_d;
    end
  end

  // Load extraction and alignment check; unknown load codes act as lw.
  always_comb begin
    addr_lo = alu_q[1:0];
    case (addr_lo)
      2'd0:    byte_sel = mdata_q[31:24];
      2'd1:    byte_sel = mdata_q[23:16];
      2'd2:    byte_sel = mdata_q[15:8];
      default: byte_sel = mdata_q[7:0];
    endcase
    half_sel  = addr_lo[1] ? mdata_q[15:0] : mdata_q[31:16];
    load_data = mdata_q;
    mis_raw   = 1'b0;
    case (ltype_q)
      3'b001: load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'b010: load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      3'b011: begin
        load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
        mis_raw   = addr_lo[0];
      end
      3'b100: begin
        load_data = {{(DATA_W-16){1'b0}}, half_sel};
        mis_raw   = addr_lo[0];
      end
      default: begin
        load_data = mdata_q;
        mis_raw   = (addr_lo != 2'd0);
      end
    endcase
    misaligned = m2r_q & mis_raw;
    reg_write  = valid_q & rw_q & (res_q != 5'd0) & ~misaligned;
  end

  // Retire counter advances only on edges where the register file commits
  // a fresh write (a stalled write is a harmless repeat, not a new retire).
  always_comb begin
    cnt_d  = cnt_q;
    aerr_d = aerr_q | (valid_q & rw_q & misaligned);
    if (reg_write && !bus.stall) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debug state: retired-write counter and sticky alignment error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      aerr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      aerr_q <= aerr_d;
    end
  end

  assign bus.regWrite  = reg_write;
  assign bus.writeRes  = res_q;
  assign bus.writeData = m2r_q ? load_data : alu_q;
  assign bus.outValid  = valid_q;
  assign bus.retireCnt = cnt_q;
  assign bus.alignErr  = aerr_q;

`ifdef MEMWB_FWD_EN
  assign bus.fwdValid = reg_write;
  assign bus.fwdRes   = res_q;
  assign bus.fwdData  = m2r_q ? load_data : alu_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases from the test plan plus
// randomized traffic against a behavioural model of the stage.
module tb_mem_wb_stage;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mem_wb_stage_if #(.CNT_W(32)) bus ();

  mem_wb_stage #(.DATA_W(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the instruction currently held, plus debug state.
  bit          m_valid, m_rw, m_m2r;
  bit [2:0]    m_ltype;
  bit [4:0]    m_res;
  bit [31:0]   m_alu, m_mdata;
  bit [31:0]   m_cnt;
  bit          m_aerr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [31:0] m_data();
    int unsigned a, b, h;
    a = m_alu % 4;
    b = (m_mdata >> (8 * (3 - a))) & 32'hFF;
    h = (m_mdata >> (16 * (1 - a / 2))) & 32'hFFFF;
    if (!m_m2r) return m_alu;
    case (m_ltype)
      3'd1:    return (b >= 128) ? (b + 32'hFFFFFF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? (h + 32'hFFFF0000) : h;
      3'd4:    return h;
      default: return m_mdata;
    endcase
  endfunction

  function automatic bit m_mis();
    int unsigned a;
    a = m_alu % 4;
    if (!m_m2r) return 1'b0;
    if (m_ltype == 3'd1 || m_ltype == 3'd2) return 1'b0;
    if (m_ltype == 3'd3 || m_ltype == 3'd4) return (a % 2) == 1;
    return a != 0;
  endfunction

  function automatic bit m_wr();
    return m_valid && m_rw && (m_res != 0) && !m_mis();
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_ltype = 0; m_res = 0;
    m_alu = 0; m_mdata = 0; m_cnt = 0; m_aerr = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".regWrite"}, {31'd0, bus.regWrite}, {31'd0, m_wr()});
    check_eq({tag, ".outValid"}, {31'd0, bus.outValid}, {31'd0, m_valid});
    check_eq({tag, ".retireCnt"}, bus.retireCnt, m_cnt);
    check_eq({tag, ".alignErr"}, {31'd0, bus.alignErr}, {31'd0, m_aerr});
    if (m_valid) begin
      check_eq({tag, ".writeRes"}, {27'd0, bus.writeRes}, {27'd0, m_res});
      check_eq({tag, ".writeData"}, bus.writeData, m_data());
    end
`ifdef MEMWB_FWD_EN
    check_eq({tag, ".fwdValid"}, {31'd0, bus.fwdValid}, {31'd0, m_wr()});
    if (m_valid) begin
      check_eq({tag, ".fwdRes"}, {27'd0, bus.fwdRes}, {27'd0, m_res});
      check_eq({tag, ".fwdData"}, bus.fwdData, m_data());
    end
`endif
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare all outputs shortly after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (m_wr() && !bus.stall) m_cnt = m_cnt + 1;
    if (m_valid && m_rw && m_mis()) m_aerr = 1'b1;
    if (bus.flush) begin
      m_valid = 1'b0;
    end else if (!bus.stall) begin
      m_valid = bus.inValid;   m_rw    = bus.inRegWrite;
      m_m2r   = bus.inMemToReg; m_ltype = bus.inLoadType;
      m_res   = bus.inWriteRes; m_alu   = bus.inAluResult;
      m_mdata = bus.inMemData;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input bit v, input bit rw, input bit m2r, input bit [2:0] lt,
                       input bit [4:0] res, input bit [31:0] alu, input bit [31:0] md,
                       input bit st, input bit fl);
    bus.inValid = v; bus.inRegWrite = rw; bus.inMemToReg = m2r; bus.inLoadType = lt;
    bus.inWriteRes = res; bus.inAluResult = alu; bus.inMemData = md;
    bus.stall = st; bus.flush = fl;
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          3'($urandom_range(0, 7)),
          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
          $urandom, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
  endtask

  typedef struct { bit [2:0] lt; bit [31:0] alu; bit [31:0] exp; string name; } load_case_t;

  initial begin
    load_case_t loads[5];
    bit [31:0]  base;
    n_cmp = 0;
    n_err = 0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    check_eq("reset.writeData", bus.writeData, 32'h0);
    check_eq("reset.writeRes", {27'd0, bus.writeRes}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) step("idle");

    // ALU write to x5, then the same to x0.
    drive(1, 1, 0, 0, 5, 32'h12345678, 32'h0, 0, 0);
    step("alu_x5");
    check_eq("alu_x5.regWrite", {31'd0, bus.regWrite}, 32'd1);
    check_eq("alu_x5.writeData", bus.writeData, 32'h12345678);
    drive(1, 1, 0, 0, 0, 32'h12345678, 32'h0, 0, 0);
    step("alu_x0");
    check_eq("alu_x0.regWrite", {31'd0, bus.regWrite}, 32'd0);
    check_eq("alu_x0.retireCnt", bus.retireCnt, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("alu_x0_after");
    check_eq("alu_x0_after.retireCnt", bus.retireCnt, 32'd1);

    // Load extraction from 0x80F17F01.
    loads[0] = '{3'd1, 32'h0, 32'hFFFFFF80, "lb_a0"};
    loads[1] = '{3'd2, 32'h1, 32'h000000F1, "lbu_a1"};
    loads[2] = '{3'd3, 32'h2, 32'h00007F01, "lh_a2"};
    loads[3] = '{3'd4, 32'h0, 32'h000080F1, "lhu_a0"};
    loads[4] = '{3'd0, 32'h0, 32'h80F17F01, "lw_a0"};
    foreach (loads[i]) begin
      drive(1, 1, 1, loads[i].lt, 5'd9, loads[i].alu, 32'h80F17F01, 0, 0);
      step(loads[i].name);
      check_eq({loads[i].name, ".data"}, bus.writeData, loads[i].exp);
      check_eq({loads[i].name, ".wr"}, {31'd0, bus.regWrite}, 32'd1);
    end

    // Misaligned lw: write suppressed, sticky error on the following edge.
    drive(1, 1, 1, 3'd0, 5'd3, 32'h1002, 32'h80F17F01, 0, 0);
    step("mis_lw");
    check_eq("mis_lw.regWrite", {31'd0, bus.regWrite}, 32'd0);
    drive(1, 1, 0, 0, 5'd4, 32'hA5A5A5A5, 32'h0, 0, 0);
    step("mis_lw_next");
    check_eq("mis_lw.alignErr", {31'd0, bus.alignErr}, 32'd1);
    repeat (3) step("mis_lw_sticky");
    check_eq("mis_lw.sticky", {31'd0, bus.alignErr}, 32'd1);

    // Stall for 3 cycles after a valid write: frozen, one retire total.
    drive(1, 1, 0, 0, 5'd7, 32'hCAFEF00D, 32'h0, 0, 0);
    step("stall_cap");
    base = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 5'd8, $urandom, $urandom, 1, 0);
      step("stall_hold");
      check_eq("stall.writeData", bus.writeData, 32'hCAFEF00D);
      check_eq("stall.retireCnt", bus.retireCnt, base);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("stall_release");
    check_eq("stall.retire_total", bus.retireCnt, base + 1);

    // Flush wins over stall.
    drive(1, 1, 0, 0, 5'd11, 32'h55AA55AA, 32'h0, 0, 0);
    step("flush_cap");
    drive(1, 1, 0, 0, 5'd12, 32'h1, 32'h0, 1, 1);
    step("flush_stall");
    check_eq("flush.outValid", {31'd0, bus.outValid}, 32'd0);
    check_eq("flush.regWrite", {31'd0, bus.regWrite}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step("rand");
    end

    // Asynchronous reset mid-stream: outputs clear before any clock edge.
    drive(1, 1, 0, 0, 5'd6, 32'h0BADBEEF, 32'h0, 0, 0);
    step("pre_reset");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    check_eq("async_reset.writeData", bus.writeData, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_reset");
    for (int i = 0; i < 100; i++) begin
      drive_random();
      step("rand2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
